lc3_stage_controller: RTL and testbench

- Pipeline sequencer for the LC-3 core. Drives the per-stage enables: fetch, decode (enable_decode into the decode stage), execute, writeback and PC update.
- Resolves branches and JMP, and runs the data-memory access FSM for LD/LDR/LDI/ST/STR/STI.
- Sits beside the fetch/decode/execute/writeback/memaccess stages. Observes the instructions held in decode and execute, plus the memory completion strobes.

---
 rtl/lc3_stage_controller.sv | 127 ++++++++++++
 tb/tb_lc3_stage_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lc3_stage_controller.sv
// LC-3 pipeline sequencer: stage enables, fill/flush sequencing, branch resolution and data-memory FSM.
// Optional stall counter output is compiled in when LC3_CTRL_STALL_CNT_EN is defined.
module lc3_stage_controller #(
  parameter int FILL_DEPTH   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir_dec,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic [1:0]  mem_state
`ifdef LC3_CTRL_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int FW = $clog2(FILL_DEPTH + 1);
  localparam int KW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_INDIRECT = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_t;

  mem_state_t    state, state_next;
  logic [FW-1:0] fill_cnt, fill_cnt_next;
  logic          fill_done;
  logic [KW-1:0] flush_cnt, flush_cnt_next;

  logic [3:0] op_exec, op_dec;
  logic       exec_load, exec_store, exec_ind, exec_br, exec_jmp, dec_ctrl;
  logic       busy, flushing, istall;
  logic       fetch_ok, decode_ok, exec_ok;

  assign op_exec    = ir_exec[15:12];
  assign op_dec     = ir_dec[15:12];
  assign exec_load  = (op_exec == 4'b0010) || (op_exec == 4'b0110);
  assign exec_store = (op_exec == 4'b0011) || (op_exec == 4'b0111);
  assign exec_ind   = (op_exec == 4'b1010) || (op_exec == 4'b1011);
  assign exec_br    = (op_exec == 4'b0000);
  assign exec_jmp   = (op_exec == 4'b1100);
  assign dec_ctrl   = (op_dec == 4'b0000) || (op_dec == 4'b1100);

  // Fill slots: fetch/PC after edge 1, decode after 2, execute after 3, writeback one edge after saturation.
  assign fetch_ok  = (fill_cnt >= FW'(1));
  assign decode_ok = (fill_cnt >= FW'(2));
  assign exec_ok   = (fill_cnt >= FW'(FILL_DEPTH));

  assign busy     = (state != MEM_IDLE);
  assign flushing = (flush_cnt != '0);
  assign istall   = fill_done & ~complete_instr;

  assign enable_execute   = exec_ok & ~busy;
  assign br_taken         = enable_execute & (exec_jmp | (exec_br & (|(ir_exec[11:9] & psr))));
  assign enable_fetch     = fetch_ok & ~busy & ~flushing & ~istall;
  assign enable_decode    = decode_ok & ~busy & ~flushing & ~istall;
  assign enable_updatePC  = fetch_ok & ~busy & (flushing ? br_taken : ~istall);
  assign enable_writeback = fill_done & (busy ? ((state == MEM_READ) & complete_data) : 1'b1);
  assign mem_state        = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= MEM_IDLE;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      fill_cnt  <= fill_cnt_next;
      fill_done <= fill_done | (fill_cnt == FW'(FILL_DEPTH));
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    fill_cnt_next  = fill_cnt;
    flush_cnt_next = flush_cnt;

    if (fill_cnt != FW'(FILL_DEPTH))
      fill_cnt_next = fill_cnt + FW'(1);

    case (state)
      MEM_IDLE: begin
        if (enable_execute) begin
          if (exec_load)       state_next = MEM_READ;
          else if (exec_store) state_next = MEM_WRITE;
          else if (exec_ind)   state_next = MEM_INDIRECT;
        end
      end
      MEM_READ:     if (complete_data) state_next = MEM_IDLE;
      MEM_WRITE:    if (complete_data) state_next = MEM_IDLE;
      MEM_INDIRECT: if (complete_data) state_next = ir_exec[12] ? MEM_WRITE : MEM_READ;
      default:      state_next = MEM_IDLE;
    endcase

    // Flush counter freezes during memory accesses; a running flush is never reloaded.
    if (!busy) begin
      if (flushing)
        flush_cnt_next = flush_cnt - KW'(1);
      else if (enable_decode && dec_ctrl)
        flush_cnt_next = KW'(FLUSH_CYCLES);
    end
  end

`ifdef LC3_CTRL_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (fill_done && !enable_fetch && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lc3_stage_controller.sv
// Scoreboard bench for lc3_stage_controller: directed vectors push expected outputs, a negedge monitor checks them.
module tb_lc3_stage_controller;

  localparam logic [15:0] NOP = 16'h1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr, complete_data;
  logic [15:0] ir_dec, ir_exec;
  logic [2:0]  psr;
  logic        enable_fetch, enable_decode, enable_execute;
  logic        enable_writeback, enable_updatePC, br_taken;
  logic [1:0]  mem_state;
`ifdef LC3_CTRL_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  lc3_stage_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .ir_dec           (ir_dec),
    .ir_exec          (ir_exec),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatePC  (enable_updatePC),
    .br_taken         (br_taken),
    .mem_state        (mem_state)
`ifdef LC3_CTRL_STALL_CNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        ci;
    logic        cd;
    logic [15:0] ird;
    logic [15:0] ire;
    logic [2:0]  p;
    logic [5:0]  en;   // {fetch, decode, execute, writeback, updatePC, br_taken}
    logic [1:0]  ms;
    logic        chk_sc;
    logic [15:0] sc;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [5:0]  en;
    logic [1:0]  ms;
    logic        chk_sc;
    logic [15:0] sc;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_v(input logic r, input logic ci, input logic cd,
                       input logic [15:0] d, input logic [15:0] e, input logic [2:0] p,
                       input logic [5:0] en, input logic [1:0] ms,
                       input logic chk = 1'b0, input logic [15:0] sc = 16'd0);
    vec_t v;
    v.rst = r; v.ci = ci; v.cd = cd; v.ird = d; v.ire = e; v.p = p;
    v.en = en; v.ms = ms; v.chk_sc = chk; v.sc = sc;
    vecs.push_back(v);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = exp_q.pop_front();
      act = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, br_taken};
      checks++;
      if (act !== e.en || mem_state !== e.ms) begin
        errors++;
        $display("FAIL vec%0d outputs: got en=%b ms=%0d, want en=%b ms=%0d", e.idx, act, mem_state, e.en, e.ms);
      end
`ifdef LC3_CTRL_STALL_CNT_EN
      if (e.chk_sc) begin
        checks++;
        if (stall_count !== e.sc) begin
          errors++;
          $display("FAIL vec%0d stall_count: got %0d, want %0d", e.idx, stall_count, e.sc);
        end
      end
`endif
    end
  end

  initial begin
    reset = 1'b0; complete_instr = 1'b1; complete_data = 1'b0;
    ir_dec = NOP; ir_exec = NOP; psr = 3'b000;

    // Reset and pipeline fill
    add_v(0,1,0,NOP,NOP,3'b000,6'b000000,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b000000,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b100010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b110010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3);
    // LD: three READ cycles, writeback on completion
    add_v(1,1,0,NOP,16'h2005,3'b000,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'h2005,3'b000,6'b000000,2'd0);
    add_v(1,1,0,NOP,16'h2005,3'b000,6'b000000,2'd0);
    add_v(1,1,1,NOP,16'h2005,3'b000,6'b000100,2'd0);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3);
    // STI: IDLE, INDIRECT, WRITE, IDLE
    add_v(1,1,0,NOP,16'hB005,3'b000,6'b111110,2'd3);
    add_v(1,1,1,NOP,16'hB005,3'b000,6'b000000,2'd1);
    add_v(1,1,1,NOP,16'hB005,3'b000,6'b000000,2'd2);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3);
    // BRnzp taken with two bubbles
    add_v(1,1,0,16'h0E02,NOP,3'b010,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'h0E02,3'b010,6'b001111,2'd3);
    add_v(1,1,0,NOP,NOP,3'b010,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b010,6'b111110,2'd3);
    // BRn not taken, flush still runs
    add_v(1,1,0,16'h0802,NOP,3'b001,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'h0802,3'b001,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b001,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b001,6'b111110,2'd3);
    // JMP always taken
    add_v(1,1,0,16'hC000,NOP,3'b000,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'hC000,3'b000,6'b001111,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3);
    // Instruction-memory stall, then BR nzp=000 never taken
    add_v(1,0,0,NOP,NOP,3'b000,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'h0002,3'b111,6'b111110,2'd3);
    // Reset asserted in the middle of LDI
    add_v(1,1,0,NOP,16'hA005,3'b000,6'b111110,2'd3);
    add_v(1,1,0,NOP,16'hA005,3'b000,6'b000000,2'd1);
    add_v(0,1,0,NOP,16'hA005,3'b000,6'b000000,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b000000,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b100010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b110010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111010,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3,1'b1,16'd0);
    // Five post-fill stall cycles
    for (int i = 0; i < 5; i++)
      add_v(1,0,0,NOP,NOP,3'b000,6'b001100,2'd3);
    add_v(1,1,0,NOP,NOP,3'b000,6'b111110,2'd3,1'b1,16'd5);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clock);
      #1;
      reset = vecs[i].rst; complete_instr = vecs[i].ci; complete_data = vecs[i].cd;
      ir_dec = vecs[i].ird; ir_exec = vecs[i].ire; psr = vecs[i].p;
      e.idx = i; e.en = vecs[i].en; e.ms = vecs[i].ms; e.chk_sc = vecs[i].chk_sc; e.sc = vecs[i].sc;
      exp_q.push_back(e);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
